// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words,
// writes them to instruction memory and releases the core after the halt word.
// Optional trailing checksum byte check is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_rst_o,
    output logic                  core_enable_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_overflow_o,
    output logic                  err_checksum_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  err_ov_q, err_ov_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic                  core_rst_q, core_rst_d;
    logic                  core_en_q, core_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  begin_load;

`ifdef LOADER_CHECKSUM_EN
    logic                  err_ck_q, err_ck_d;
    assign err_checksum_o = err_ck_q;
`else
    assign err_checksum_o = 1'b0;
`endif

    // Byte handshake: ready is a registered copy of "state is LOAD or CHECK".
    assign accept = byte_valid_i && ready_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        err_ov_d   = err_ov_q;
`ifdef LOADER_CHECKSUM_EN
        err_ck_d   = err_ck_q;
`endif
        begin_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin_load = 1'b1;
            end
            S_LOAD: begin
                if (accept) begin
                    word_d[{idx_q, 3'b000} +: 8] = byte_in_i;
                    sum_d = sum_q + byte_in_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (word_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_RUN;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d  = S_ERROR;
                    err_ov_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (byte_in_i == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d  = S_ERROR;
                        err_ck_d = 1'b1;
                    end
                end
            end
`endif
            S_RUN, S_ERROR: begin
                if (start_i) begin_load = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // (Re)start clears all per-load bookkeeping and error status.
        if (begin_load) begin
            state_d  = S_LOAD;
            addr_d   = '0;
            idx_d    = '0;
            word_d   = '0;
            cnt_d    = '0;
            sum_d    = '0;
            err_ov_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_ck_d = 1'b0;
`endif
        end

        ready_d    = (state_d == S_LOAD) || (state_d == S_CHECK);
        we_d       = (state_d == S_WRITE);
        core_rst_d = (state_d != S_RUN);
        core_en_d  = (state_d == S_RUN);
        done_d     = (state_d == S_RUN);
        busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_CHECK);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            err_ov_q   <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            err_ov_q   <= err_ov_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_ck_q <= 1'b0;
        else         err_ck_q <= err_ck_d;
    end
`endif

    assign byte_ready_o   = ready_q;
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = word_q;
    assign core_rst_o     = core_rst_q;
    assign core_enable_o  = core_en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_overflow_o = err_ov_q;
    assign word_count_o   = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboarded memory writes plus per-scenario status checks.
// Main DUT uses default ADDR_WIDTH; a second DUT with ADDR_WIDTH=2 shares the inputs
// to exercise the overflow path. Honours LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        ready, we, core_rst, core_en, busy, done, err_ov, err_ck;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  wcnt;

    logic        o_ready, o_we, o_core_rst, o_core_en, o_busy, o_done, o_err_ov, o_err_ck;
    logic [1:0]  o_addr;
    logic [31:0] o_wdata;
    logic [2:0]  o_wcnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [39:0] sb_q[$];
    logic [39:0] mon_e;
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  sum_exp = 8'h00;

    imem_loader u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(ready), .imem_we_o(we),
        .imem_addr_o(addr), .imem_wdata_o(wdata), .core_rst_o(core_rst),
        .core_enable_o(core_en), .busy_o(busy), .done_o(done),
        .err_overflow_o(err_ov), .err_checksum_o(err_ck), .word_count_o(wcnt)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_dut_ov (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(o_ready), .imem_we_o(o_we),
        .imem_addr_o(o_addr), .imem_wdata_o(o_wdata), .core_rst_o(o_core_rst),
        .core_enable_o(o_core_en), .busy_o(o_busy), .done_o(o_done),
        .err_overflow_o(o_err_ov), .err_checksum_o(o_err_ck), .word_count_o(o_wcnt)
    );

    always #5 clk = ~clk;

    // Write monitor: every memory write of the main DUT must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && we) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL imem_write: unexpected write addr=%h data=%h", addr, wdata);
            end else begin
                mon_e = sb_q.pop_front();
                if ({addr, wdata} !== mon_e)
                begin
                    miscompares++;
                    $display("FAIL imem_write: got addr=%h data=%h, expected addr=%h data=%h",
                             addr, wdata, mon_e[39:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte and hold it until accepted; called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_ready_timeout: ready=%b after %0d cycles, expected 1", ready, t);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        logic [7:0] b;
        sb_q.push_back({exp_addr, w});
        exp_addr++;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            sum_exp = sum_exp + b;
            if (stall) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 8'h00;
        sum_exp  = 8'h00;
    endtask

    task automatic load_basic(input bit stall);
        pulse_start();
        send_word(32'h0010_0013, stall);
        send_word(32'hFFFF_FFFF, stall);
    endtask

    // Called in the halt-word WRITE cycle; finishes the load and checks the core is released.
    task automatic finish_run(input string name);
        if (core_en !== 1'b0 || we !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_write_cycle: core_en=%b we=%b, expected 0 1", name, core_en, we);
        end
        vectors++;
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum_exp);
`else
        @(negedge clk);
`endif
        vectors++;
        if ({core_en, core_rst, done, busy} !== 4'b1010) begin
            miscompares++;
            $display("FAIL %s_run: {en,rst,done,busy}=%b, expected 1010", name,
                     {core_en, core_rst, done, busy});
        end
    endtask

    task automatic check_sb_empty(input string name);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_sb_empty: %0d writes missing, expected 0", name, sb_q.size());
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        byte_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({core_rst, core_en, ready, we, done, busy, err_ov, err_ck} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 10000000",
                     {core_rst, core_en, ready, we, done, busy, err_ov, err_ck});
        end
        vectors++;
        if ({addr, wdata, wcnt} !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_regs: addr=%h wdata=%h wcnt=%0d, expected 0", addr, wdata, wcnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({ready, busy, core_rst} !== 3'b001) begin
            miscompares++;
            $display("FAIL idle_flags: {ready,busy,core_rst}=%b, expected 001", {ready, busy, core_rst});
        end
    endtask

    task automatic test_basic_load();
        load_basic(1'b0);
        finish_run("basic");
        vectors++;
        if (wcnt !== 9'd2) begin
            miscompares++;
            $display("FAIL basic_word_count: got %0d, expected 2", wcnt);
        end
        check_sb_empty("basic");
    endtask

    task automatic test_stalled();
        load_basic(1'b1);
        finish_run("stalled");
        vectors++;
        if (wcnt !== 9'd2) begin
            miscompares++;
            $display("FAIL stalled_word_count: got %0d, expected 2", wcnt);
        end
        check_sb_empty("stalled");
    endtask

    task automatic test_restart();
        pulse_start();
        vectors++;
        if ({core_rst, core_en, done, busy, ready, wcnt} !== {5'b10011, 9'd0}) begin
            miscompares++;
            $display("FAIL restart_flags: {rst,en,done,busy,ready}=%b wcnt=%0d, expected 10011 0",
                     {core_rst, core_en, done, busy, ready}, wcnt);
        end
        send_word(32'h0020_0093, 1'b0);
        @(negedge clk);
        vectors++;
        if ({done, addr, wcnt} !== {1'b0, 8'd1, 9'd1}) begin
            miscompares++;
            $display("FAIL restart_mid: done=%b addr=%0d wcnt=%0d, expected 0 1 1", done, addr, wcnt);
        end
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_run("restart");
        check_sb_empty("restart");
    endtask

    task automatic test_reset_mid_word();
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        apply_reset();
        pulse_start();
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_run("mid_reset");
        check_sb_empty("mid_reset");
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(32'h0000_0013, 1'b0);
        @(negedge clk);
        vectors++;
        if ({o_err_ov, o_core_rst, o_core_en, o_busy, o_done, o_wcnt} !== {5'b11000, 3'd4}) begin
            miscompares++;
            $display("FAIL overflow_flags: {ov,rst,en,busy,done}=%b wcnt=%0d, expected 11000 4",
                     {o_err_ov, o_core_rst, o_core_en, o_busy, o_done}, o_wcnt);
        end
        vectors++;
        if ({busy, err_ov, addr, wcnt} !== {2'b10, 8'd4, 9'd4}) begin
            miscompares++;
            $display("FAIL wide_no_overflow: busy=%b ov=%b addr=%0d wcnt=%0d, expected 1 0 4 4",
                     busy, err_ov, addr, wcnt);
        end
        check_sb_empty("overflow");
        pulse_start();
        vectors++;
        if ({o_err_ov, o_busy, o_core_rst, o_wcnt} !== {3'b011, 3'd0}) begin
            miscompares++;
            $display("FAIL error_restart: {ov,busy,rst}=%b wcnt=%0d, expected 011 0",
                     {o_err_ov, o_busy, o_core_rst}, o_wcnt);
        end
        vectors++;
        if ({busy, wcnt} !== {1'b1, 9'd4}) begin
            miscompares++;
            $display("FAIL start_ignored_in_load: busy=%b wcnt=%0d, expected 1 4", busy, wcnt);
        end
        apply_reset();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        load_basic(1'b0);
        @(negedge clk);
        vectors++;
        if ({ready, busy, core_en} !== 3'b110) begin
            miscompares++;
            $display("FAIL check_state: {ready,busy,en}=%b, expected 110", {ready, busy, core_en});
        end
        send_byte(8'h20);
        vectors++;
        if ({err_ck, core_rst, core_en, done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL checksum_bad: {err_ck,rst,en,done}=%b, expected 1100",
                     {err_ck, core_rst, core_en, done});
        end
        check_sb_empty("checksum");
        load_basic(1'b0);
        send_byte(8'h1F);
        vectors++;
        if ({err_ck, core_en, done} !== 3'b011) begin
            miscompares++;
            $display("FAIL checksum_good: {err_ck,en,done}=%b, expected 011", {err_ck, core_en, done});
        end
        check_sb_empty("checksum_good");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_stalled();
        test_restart();
        test_reset_mid_word();
        test_overflow();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
